// File: rtl/ddr_readback_checker.sv
// Read-back checker for the user0 Avalon-MM DDR port: compares every returned beat
// against an address-derived pattern, tracks burst/pass boundaries and guards stalled bursts.
module ddr_readback_checker #(
    parameter int unsigned          ADDR_W     = 25,
    parameter int unsigned          DATA_W     = 64,
    parameter int unsigned          BURST_LEN  = 4,
    parameter logic [ADDR_W-1:0]    START_ADDR = 25'h000_0000,
    parameter logic [ADDR_W-1:0]    END_ADDR   = 25'h100_0000,
    parameter logic [15:0]          TIMEOUT    = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              clear_err,
    input  logic [DATA_W-1:0] user0_avl_readdata,
    input  logic              user0_avl_readdatavalid,
    output logic [15:0]       err_cnt,
    output logic              err_flag,
    output logic              timeout_flag,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       pass_cnt,
    output logic              pass_done,
    output logic              busy
);

    localparam int unsigned       IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned       CNT_W     = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = END_ADDR + ADDR_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PASS_END
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  exp_addr_q, exp_addr_d;
    logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
    logic [15:0]        wdog_q, wdog_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic [ADDR_W-1:0]  first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0]  first_err_data_q, first_err_data_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic               pass_done_q, pass_done_d;
    logic               busy_q, busy_d;

    logic [ADDR_W-1:0]  cur_addr;
    logic [IDX_W-1:0]   cur_idx;
    logic [31:0]        pat_z;
    logic [DATA_W-1:0]  exp_data;
    logic               beat_chk;
    logic               mismatch;
    logic               wdog_fire;

    // Address/index the current beat is judged against; PASS_END restarts at the pass base
    always_comb begin
        cur_addr = (state_q == ST_CHECK) ? exp_addr_q : START_ADDR;
        cur_idx  = (state_q == ST_CHECK) ? beat_idx_q : '0;
        pat_z    = 32'(cur_addr);
        exp_data = DATA_W'({~pat_z, pat_z});
        beat_chk = user0_avl_readdatavalid && (state_q != ST_IDLE);
        mismatch = beat_chk && (user0_avl_readdata != exp_data);
    end

    // Sequencing: pass walk, watchdog and state transitions
    always_comb begin
        state_d    = state_q;
        exp_addr_d = exp_addr_q;
        beat_idx_d = beat_idx_q;
        wdog_d     = '0;
        wdog_fire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                exp_addr_d = START_ADDR;
                beat_idx_d = '0;
                if (arm) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (user0_avl_readdatavalid) begin
                    exp_addr_d = cur_addr + ADDR_W'(1);
                    beat_idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
                    if (cur_addr == LAST_ADDR) begin
                        state_d = ST_PASS_END;
                    end
                end else if (beat_idx_q != '0) begin
                    if (wdog_q == TIMEOUT - 16'd1) begin
                        // Abandon the stalled burst and resume at the next burst base
                        wdog_fire  = 1'b1;
                        beat_idx_d = '0;
                        exp_addr_d = exp_addr_q + ADDR_W'(BURST_LEN) - ADDR_W'(beat_idx_q);
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS_END: begin
                if (user0_avl_readdatavalid) begin
                    exp_addr_d = cur_addr + ADDR_W'(1);
                    beat_idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
                end else begin
                    exp_addr_d = START_ADDR;
                    beat_idx_d = '0;
                end
                state_d = arm ? ST_CHECK : ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                exp_addr_d = START_ADDR;
                beat_idx_d = '0;
            end
        endcase
    end

    // Error bookkeeping; a coincident clear is applied before the current beat's result
    always_comb begin
        err_cnt_d        = clear_err ? '0 : err_cnt_q;
        err_flag_d       = clear_err ? 1'b0 : err_flag_q;
        timeout_flag_d   = clear_err ? 1'b0 : timeout_flag_q;
        first_err_addr_d = clear_err ? '0 : first_err_addr_q;
        first_err_data_d = clear_err ? '0 : first_err_data_q;

        if (mismatch) begin
            if ((err_cnt_d == '0) && !timeout_flag_d) begin
                first_err_addr_d = cur_addr;
                first_err_data_d = user0_avl_readdata;
            end
            if (err_cnt_d != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_d + CNT_W'(1);
            end
            err_flag_d = 1'b1;
        end

        if (wdog_fire) begin
            timeout_flag_d = 1'b1;
            err_flag_d     = 1'b1;
        end

        pass_done_d = (state_d == ST_PASS_END);
        pass_cnt_d  = pass_done_d ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
        busy_d      = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            exp_addr_q       <= START_ADDR;
            beat_idx_q       <= '0;
            wdog_q           <= '0;
            err_cnt_q        <= '0;
            err_flag_q       <= 1'b0;
            timeout_flag_q   <= 1'b0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            pass_cnt_q       <= '0;
            pass_done_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_addr_q       <= exp_addr_d;
            beat_idx_q       <= beat_idx_d;
            wdog_q           <= wdog_d;
            err_cnt_q        <= err_cnt_d;
            err_flag_q       <= err_flag_d;
            timeout_flag_q   <= timeout_flag_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            pass_cnt_q       <= pass_cnt_d;
            pass_done_q      <= pass_done_d;
            busy_q           <= busy_d;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign err_flag       = err_flag_q;
    assign timeout_flag   = timeout_flag_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign pass_cnt       = pass_cnt_q;
    assign pass_done      = pass_done_q;
    assign busy           = busy_q;

endmodule

// File: doc/ddr_readback_checker.md
Name: ddr_readback_checker

Overview:
- Consumes the read-data side of the user0 Avalon-MM DDR port: readdata/readdatavalid returned for the 4-beat bursts issued by the read-all-memory sequencer.
- Checks every beat against an address-derived pattern and tracks beat, burst and pass boundaries.
- Reports errors, first-failure capture and pass completion to the test top level; detects stalled bursts with a watchdog.

Parameters:
- ADDR_W, 25, word-address width
- DATA_W, 64, data width
- BURST_LEN, 4, beats per burst
- START_ADDR, 25'h000_0000, first word address of the pass
- END_ADDR, 25'h100_0000, base address of the last burst in the pass
- TIMEOUT, 16'd1000, max clk cycles between beats inside an open burst

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level; checking runs while high (tied to test_complete)
- clear_err  in  1  one-cycle pulse; clears error state
- user0_avl_readdata  in  64  read beat data
- user0_avl_readdatavalid  in  1  beat valid
- err_cnt  out  16  mismatching beats, saturates at 16'hFFFF
- err_flag  out  1  sticky: any mismatch or timeout since reset/clear
- timeout_flag  out  1  sticky: watchdog expired
- first_err_addr  out  25  word address of first mismatch
- first_err_data  out  64  data of first mismatch
- pass_cnt  out  16  completed passes, wraps at 16'hFFFF->0
- pass_done  out  1  one-cycle pulse at pass end
- busy  out  1  high in CHECK

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; exp_addr=START_ADDR; beat_idx=0; wdog=0.
- Expected data for word address A: {~Z, Z}, where Z = {7'b0, A} (32 bits).
- States:
  - IDLE: exp_addr=START_ADDR, beat_idx=0; arm=1 -> CHECK next cycle. Beats arriving in IDLE are ignored.
  - CHECK: busy=1. Each valid beat is compared in the cycle it arrives (registered result, 1-cycle latency to counters/flags). Then exp_addr+=1 and beat_idx=(beat_idx+1) mod BURST_LEN. A beat at address END_ADDR+BURST_LEN-1 -> PASS_END. arm=0 -> IDLE, aborting the pass without pulsing pass_done.
  - PASS_END: one cycle; pass_done=1, pass_cnt+=1, exp_addr=START_ADDR, beat_idx=0; -> CHECK if arm, else IDLE. A beat arriving in PASS_END is checked as START_ADDR and advances exp_addr to START_ADDR+1.
- Mismatch: err_cnt+=1 (saturating), err_flag=1. If this is the first error (err_cnt was 0 and timeout_flag was 0), load first_err_addr/first_err_data.
- Watchdog: counts cycles in CHECK while beat_idx!=0 with no valid beat; cleared on every valid beat or when beat_idx=0. When wdog reaches TIMEOUT: timeout_flag=1, err_flag=1, beat_idx=0, and exp_addr is rounded up to the next burst base.
- clear_err: zeroes err_cnt, err_flag, timeout_flag, first_err_*. Does not touch pass_cnt or state. If a mismatching beat arrives in the same cycle, clear applies first, so err_cnt=1, err_flag=1 and first_err_* are captured from that beat.
- Address arithmetic is ADDR_W bits, unsigned, with natural wrap.
- rst_n low mid-pass: immediate async clear; the partial pass is not counted.

Test Plan:
- Clean pass: arm=1, feed bursts from 0 to END_ADDR with correct pattern (set END_ADDR=8) -> 12 beats checked, err_cnt=0, one pass_done pulse after the beat at address 11, pass_cnt=1.
- Single corruption: beat at address 5 = 64'h0 -> err_cnt=1, err_flag=1, first_err_addr=5, first_err_data=0; later corruption at address 9 leaves first_err_* unchanged and err_cnt=2.
- Stalled burst: 2 beats, then no valid beat for TIMEOUT cycles -> timeout_flag=1, err_flag=1; next beat is checked as address 4.
- clear_err with a coincident bad beat at address 3 -> err_cnt=1, first_err_addr=3.
- Abort/reset: arm drops mid-pass -> busy=0, no pass_done; re-arm and the pass restarts from START_ADDR. rst_n pulse mid-pass -> all outputs 0 asynchronously.
- Saturation: force 65540 bad beats -> err_cnt holds at 16'hFFFF.
